coproc_cmd_issuer: RTL
======================

// Module: coproc_cmd_issuer
// PURPOSE
//  Host-side initiator for the image coprocessor's instruction port. It accepts queued commands
//  (op/addr/data) over a valid/ready handshake and drives INSTRUCTION/MEM_ADDR/DATA_IN/ENABLE.
//  It then waits for a fresh FLAG_DONE and returns DATA_OUT plus a status word to the host.
//  Sits between the HPS/PIO bridge and the coprocessor top.
// PARAMETERS
//  ENABLE_HOLD     4        cycles ENABLE is held high per issue (>=2)
//  TIMEOUT_CYCLES  1000000  max cycles in either wait state before TIMEOUT status
//  TIMER_W         20       width of hold/timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   synchronous reset, active low
//  cmd_valid      in   1   host command valid
//  cmd_ready      out  1   issuer can accept a command (high only in IDLE)
//  cmd_op         in   3   000 NOP,001 LOAD,010 STORE,011 ZIN_VP,100 ZIN_RP,101 ZOUT_MP,110 ZOUT_VD,111 RESET
//  cmd_addr       in   18  memory address for the coprocessor
//  cmd_data       in   8   write data for STORE
//  INSTRUCTION    out  3   to coprocessor
//  MEM_ADDR       out  18  to coprocessor
//  DATA_IN        out  8   to coprocessor
//  ENABLE         out  1   to coprocessor
//  FLAG_DONE      in   1   from coprocessor; level, sticky until the next op begins
//  FLAG_ERROR     in   1   from coprocessor
//  FLAG_ZOOM_MAX  in   1   from coprocessor
//  FLAG_ZOOM_MIN  in   1   from coprocessor
//  DATA_OUT       in   8   from coprocessor
//  rsp_valid      out  1   response valid; held until rsp_ready
//  rsp_ready      in   1   host accepts response
//  rsp_data       out  8   DATA_OUT captured at done (0 for NOP/RESET/timeout)
//  rsp_status     out  2   00 OK, 01 ERROR, 10 TIMEOUT, 11 reserved (never driven)
//  rsp_zoom       out  2   {FLAG_ZOOM_MAX,FLAG_ZOOM_MIN} captured at done
//  busy           out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge):
//   - state=IDLE; all outputs 0 except cmd_ready=1.
//   - Reset mid-operation aborts at once: ENABLE drops next cycle and no response is produced.
//  IDLE: on cmd_valid&&cmd_ready, latch op/addr/data onto INSTRUCTION/MEM_ADDR/DATA_IN
//   (held stable until back in IDLE); cmd_ready=0 the next cycle.
//   - NOP   -> RESPOND directly; rsp_status=00, rsp_data=0; ENABLE never asserted.
//   - other -> ISSUE.
//  ISSUE: ENABLE=1 for exactly ENABLE_HOLD cycles, then ENABLE=0.
//   - RESET op -> RESPOND (fire-and-forget, status 00).
//   - otherwise -> WAIT_CLR.
//  WAIT_CLR: wait for FLAG_DONE=0, which rejects the stale done from the previous op.
//   - FLAG_DONE may already be low on entry; the move to WAIT_DONE is then taken that cycle.
//  WAIT_DONE: on the first cycle with FLAG_DONE=1:
//   - capture DATA_OUT, zoom flags and FLAG_ERROR (status 01 if set, else 00); go to RESPOND.
//   - ENABLE stays 0 here; zoom ops complete only with ENABLE low.
//  RESPOND: rsp_valid=1, rsp_* stable; on rsp_ready -> IDLE, rsp_valid=0 next cycle.
//   - rsp_ready while rsp_valid=0 is ignored.
//  Latency (no stalls): NOP response 1 cycle after accept.
//   - Other ops: ENABLE_HOLD + clear wait + done wait + 1.
//  Timer: TIMER_W-bit up-counter, cleared on every state entry; it never wraps (saturates).
//  Simultaneous events:
//   - cmd_valid during a non-IDLE state is not accepted (cmd_ready=0).
//   - FLAG_DONE rising on the same edge as entry into WAIT_DONE counts as done.
// CONFIGURATION
//  CMD_ISSUER_TIMEOUT_EN defined:
//   - In WAIT_CLR or WAIT_DONE, if the timer reaches TIMEOUT_CYCLES-1 with no exit, go to RESPOND.
//   - That response carries rsp_status=10, rsp_data=0, rsp_zoom=0.
//  Not defined: the timer is removed; the wait states wait indefinitely; status 10 never occurs.
// TESTING
//  1 reset_n=0 for 3 cycles mid-WAIT_DONE -> ENABLE=0, cmd_ready=1, rsp_valid=0, busy=0.
//  2 NOP accepted -> next cycle rsp_valid=1, status 00, data 0; ENABLE never high.
//  3 LOAD addr 0x00123, model FLAG_DONE high (stale) then low 2 cycles, then high with DATA_OUT=0xA5
//    -> ENABLE high 4 cycles; rsp_data=0xA5, status 00; the stale done is not taken.
//  4 STORE data 0x3C, FLAG_ERROR=1 at done -> DATA_IN=0x3C held; rsp_status=01.
//  5 ZOUT_MP, hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=16, FLAG_DONE stuck 0 -> RESPOND 16 cycles after WAIT_DONE entry, status 10.

Source files
------------

// File: rtl/coproc_cmd_issuer.sv
// Coprocessor command issuer: accepts one host command, pulses ENABLE, waits for a fresh FLAG_DONE and holds the response until rsp_ready.
// NOP answers 1 cycle after accept, others ENABLE_HOLD + clear + done waits + 1; optional wait timeout under CMD_ISSUER_TIMEOUT_EN.
module coproc_cmd_issuer #(
  parameter int ENABLE_HOLD    = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_W        = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [17:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [2:0]  INSTRUCTION,
  output logic [17:0] MEM_ADDR,
  output logic [7:0]  DATA_IN,
  output logic        ENABLE,
  input  logic        FLAG_DONE,
  input  logic        FLAG_ERROR,
  input  logic        FLAG_ZOOM_MAX,
  input  logic        FLAG_ZOOM_MIN,
  input  logic [7:0]  DATA_OUT,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status,
  output logic [1:0]  rsp_zoom,
  output logic        busy
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_RESET = 3'b111;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERROR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(ENABLE_HOLD - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_CLR, S_WAIT_DONE, S_RESPOND
  } state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic               timeout_hit;

`ifdef CMD_ISSUER_TIMEOUT_EN
  assign timeout_hit = (timer == TIMER_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cmd_valid) state_nxt = (cmd_op == OP_NOP) ? S_RESPOND : S_ISSUE;
      S_ISSUE:     if (timer == HOLD_LAST)
                     state_nxt = (INSTRUCTION == OP_RESET) ? S_RESPOND : S_WAIT_CLR;
      S_WAIT_CLR:  if (!FLAG_DONE)       state_nxt = S_WAIT_DONE;
                   else if (timeout_hit) state_nxt = S_RESPOND;
      S_WAIT_DONE: if (FLAG_DONE || timeout_hit) state_nxt = S_RESPOND;
      S_RESPOND:   if (rsp_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    ENABLE    = (state == S_ISSUE);
    rsp_valid = (state == S_RESPOND);
    busy      = (state != S_IDLE);
  end

  // Restarts on every state change; capping at TIMEOUT_CYCLES-1 keeps it from wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n)                timer <= '0;
    else if (state_nxt != state) timer <= '0;
    else if (timer != TIMER_MAX) timer <= timer + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      INSTRUCTION <= '0;
      MEM_ADDR    <= '0;
      DATA_IN     <= '0;
      rsp_data    <= '0;
      rsp_status  <= ST_OK;
      rsp_zoom    <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        INSTRUCTION <= cmd_op;
        MEM_ADDR    <= cmd_addr;
        DATA_IN     <= cmd_data;
      end
      if (state != S_RESPOND && state_nxt == S_RESPOND) begin
        if (state == S_WAIT_DONE && FLAG_DONE) begin
          rsp_data   <= DATA_OUT;
          rsp_zoom   <= {FLAG_ZOOM_MAX, FLAG_ZOOM_MIN};
          rsp_status <= FLAG_ERROR ? ST_ERROR : ST_OK;
        end else begin
          // NOP, RESET and timeout carry no coprocessor data.
          rsp_data   <= '0;
          rsp_zoom   <= '0;
          rsp_status <= (state == S_WAIT_CLR || state == S_WAIT_DONE) ? ST_TIMEOUT : ST_OK;
        end
      end
    end
  end

endmodule
